// File: rtl/gcm_sequencer.sv
// gcm_sequencer: drives the GCTR engine through H, E(K,Y0) and N counter-mode blocks per message.
// Optional request watchdog enabled by defining GCM_SEQ_TIMEOUT_EN.
module gcm_sequencer #(
  parameter int CNT_W     = 16,
  parameter int TO_CYCLES = 255
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic [0:255]     iKey,
  input  logic             iKeylen,
  input  logic             iEncdec,
  input  logic [0:95]      iIV,
  input  logic [CNT_W-1:0] iNumBlocks,
  input  logic [0:127]     iBlock,
  input  logic             iBlock_valid,
  output logic             oBlock_ready,
  output logic [0:127]     oH,
  output logic             oH_valid,
  output logic [0:127]     oEkY0,
  output logic             oEkY0_valid,
  output logic [0:127]     oData,
  output logic             oData_valid,
  output logic             oBusy,
  output logic             oDone,
  output logic             oError,
  output logic             oGctrRst,
  output logic             oGctrInit,
  output logic [0:255]     oGctrKey,
  output logic             oGctrKey_valid,
  output logic             oGctrKeylen,
  output logic             oGctrEncdec,
  output logic [0:95]      oGctrIV,
  output logic             oGctrIV_valid,
  output logic             oGctrHashKey,
  output logic             oGctrY0,
  output logic [0:127]     oGctrBlock,
  output logic             oGctrBlock_valid,
  input  logic [0:127]     iGctrResult,
  input  logic             iGctrResult_valid
);
  typedef enum logic [3:0] {IDLE, CLR, REQ_H, GAP_H, REQ_Y0, GAP_Y0, WAIT_IN, REQ_BLK, GAP_BLK, DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_abt, w_start, w_req, w_to, w_abort, w_res;
  assign w_start = r_state == IDLE && iStart;
  assign w_req   = r_state inside {REQ_H, REQ_Y0, REQ_BLK};
  assign w_abort = r_state != IDLE && (iAbort || w_to);
  assign w_res   = w_req && iGctrResult_valid && !w_abort;
`ifdef GCM_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1) < 8 ? 8 : $clog2(TO_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic r_err;
  assign w_to   = w_req && !iGctrResult_valid && r_wd == WD_W'(TO_CYCLES - 1);
  assign oError = r_err;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd  <= w_req && !iGctrResult_valid ? r_wd + 1'b1 : '0;
      r_err <= w_to | (r_err & ~w_start);
    end
  end
`else
  assign w_to   = 1'b0;
  assign oError = 1'b0;
`endif
  always_ff @(posedge iClk) r_state <= iRst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = CLR;
    else case (r_state)
      IDLE:    w_next = iStart ? CLR : IDLE;
      CLR:     w_next = r_abt ? IDLE : REQ_H;
      REQ_H:   w_next = iGctrResult_valid ? GAP_H : REQ_H;
      GAP_H:   w_next = REQ_Y0;
      REQ_Y0:  w_next = iGctrResult_valid ? GAP_Y0 : REQ_Y0;
      GAP_Y0:  w_next = r_cnt == '0 ? DONE : WAIT_IN;
      WAIT_IN: w_next = iBlock_valid ? REQ_BLK : WAIT_IN;
      REQ_BLK: w_next = iGctrResult_valid ? GAP_BLK : REQ_BLK;
      GAP_BLK: w_next = r_cnt > CNT_W'(1) ? WAIT_IN : DONE;
      default: w_next = IDLE;
    endcase
  end
  // r_abt is only consulted in CLR, so it marks a CLR entered by abort/timeout
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_abt <= 1'b0; r_cnt <= '0;
      oGctrKey <= '0; oGctrKeylen <= 1'b0; oGctrEncdec <= 1'b0; oGctrIV <= '0; oGctrBlock <= '0;
      oGctrInit <= 1'b0; oGctrHashKey <= 1'b0; oGctrY0 <= 1'b0; oGctrRst <= 1'b0;
      oBlock_ready <= 1'b0; oBusy <= 1'b0; oDone <= 1'b0;
      oH <= '0; oEkY0 <= '0; oData <= '0;
      oH_valid <= 1'b0; oEkY0_valid <= 1'b0; oData_valid <= 1'b0;
    end else begin
      r_abt <= w_abort;
      if (w_start) begin
        oGctrKey <= iKey; oGctrKeylen <= iKeylen; oGctrEncdec <= iEncdec; oGctrIV <= iIV; r_cnt <= iNumBlocks;
      end else if (r_state == GAP_BLK && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      oGctrBlock   <= w_next == REQ_BLK ? (r_state == WAIT_IN ? iBlock : oGctrBlock) : '0;
      oGctrInit    <= w_next inside {REQ_H, REQ_Y0, REQ_BLK};
      oGctrHashKey <= w_next == REQ_H;
      oGctrY0      <= w_next == REQ_Y0;
      oGctrRst     <= w_next == CLR;
      oBlock_ready <= w_next == WAIT_IN;
      oBusy        <= w_next != IDLE;
      oDone        <= w_next == DONE;
      oH_valid     <= w_res && r_state == REQ_H;
      oEkY0_valid  <= w_res && r_state == REQ_Y0;
      oData_valid  <= w_res && r_state == REQ_BLK;
      oH    <= w_res && r_state == REQ_H   ? iGctrResult : oH;
      oEkY0 <= w_res && r_state == REQ_Y0  ? iGctrResult : oEkY0;
      oData <= w_res && r_state == REQ_BLK ? iGctrResult : oData;
    end
  end
  assign oGctrKey_valid   = oGctrInit;
  assign oGctrIV_valid    = oGctrInit;
  assign oGctrBlock_valid = oGctrInit;
endmodule

// File: tb/tb_gcm_sequencer.sv
// tb_gcm_sequencer: scoreboard bench for gcm_sequencer with a behavioural GCTR engine responder.
module tb_gcm_sequencer;
  localparam int LAT = 3;
  localparam logic [0:127] HC = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  localparam logic [0:127] YC = 128'h58E2FCCEFA7E3061367F1D57A4E7455A;
  localparam logic [0:127] KS = 128'h0388DACE60B6A392F328C2B971B2FE78;
  localparam logic [0:255] K2 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [0:255] K3 = 256'hDEADBEEF00000000000000000000000000000000000000000000000000C0FFEE;
  localparam logic [0:95]  IV2 = 96'hCAFEBABEFACEDBADDECAF888;
  logic iClk = 0, iRst = 1, iStart = 0, iAbort = 0, iKeylen = 0, iEncdec = 0, iBlock_valid = 0;
  logic [0:255] iKey = '0;
  logic [0:95] iIV = '0;
  logic [15:0] iNumBlocks = '0;
  logic [0:127] iBlock = '0, iGctrResult = '0;
  logic iGctrResult_valid = 0;
  logic oBlock_ready, oH_valid, oEkY0_valid, oData_valid, oBusy, oDone, oError, oGctrRst, oGctrInit;
  logic oGctrKey_valid, oGctrKeylen, oGctrEncdec, oGctrIV_valid, oGctrHashKey, oGctrY0, oGctrBlock_valid;
  logic [0:127] oH, oEkY0, oData, oGctrBlock;
  logic [0:255] oGctrKey;
  logic [0:95] oGctrIV;
  int n_chk = 0, n_fail = 0, cyc = 0, last_y = 0, ecnt = 0, ectr = 0, g;
  bit hold = 0;
  logic [0:127] h_q[$], y_q[$], d_q[$];
  int done_q[$];
  logic [0:255] e_key = '0;
  logic [0:95] e_iv = '0;
  logic e_kl = 0, e_ed = 0;

  gcm_sequencer dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort), .iKey(iKey), .iKeylen(iKeylen),
    .iEncdec(iEncdec), .iIV(iIV), .iNumBlocks(iNumBlocks), .iBlock(iBlock), .iBlock_valid(iBlock_valid),
    .oBlock_ready(oBlock_ready), .oH(oH), .oH_valid(oH_valid), .oEkY0(oEkY0), .oEkY0_valid(oEkY0_valid),
    .oData(oData), .oData_valid(oData_valid), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oGctrRst(oGctrRst), .oGctrInit(oGctrInit), .oGctrKey(oGctrKey), .oGctrKey_valid(oGctrKey_valid),
    .oGctrKeylen(oGctrKeylen), .oGctrEncdec(oGctrEncdec), .oGctrIV(oGctrIV), .oGctrIV_valid(oGctrIV_valid),
    .oGctrHashKey(oGctrHashKey), .oGctrY0(oGctrY0), .oGctrBlock(oGctrBlock),
    .oGctrBlock_valid(oGctrBlock_valid), .iGctrResult(iGctrResult), .iGctrResult_valid(iGctrResult_valid)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected pulse, expected none", nm);
  endtask

  // engine stand-in: fixed latency, H/Y0/data results derived from the request fields
  always @(negedge iClk) begin
    iGctrResult_valid = 0;
    if (iRst || oGctrRst) begin
      ecnt = 0;
      ectr = 0;
    end else if (oGctrInit) begin
      ecnt++;
      if (ecnt == LAT && !hold) begin
        iGctrResult_valid = 1;
        iGctrResult = oGctrHashKey ? HC ^ oGctrKey[0:127] : oGctrY0 ? YC ^ {oGctrIV, 32'h0} : KS ^ oGctrBlock ^ 128'(ectr);
        if (!oGctrHashKey && !oGctrY0) ectr++;
      end
    end else ecnt = 0;
  end

  always @(negedge iClk) begin
    cyc++;
    if (oGctrInit) begin
      chk("req_cfg", 256'({oGctrKeylen, oGctrEncdec, oGctrKey_valid, oGctrIV_valid, oGctrBlock_valid}), 256'({e_kl, e_ed, 3'b111}));
      chk("req_key", oGctrKey, e_key);
      chk("req_iv", 256'(oGctrIV), 256'(e_iv));
      if (oGctrHashKey) chk("req_h_blk", 256'(oGctrBlock), 256'(0));
    end
    if (oH_valid) begin
      if (h_q.size() == 0) unexp("oH_valid");
      else chk("oH", 256'(oH), 256'(h_q.pop_front()));
    end
    if (oEkY0_valid) begin
      last_y = cyc;
      if (y_q.size() == 0) unexp("oEkY0_valid");
      else chk("oEkY0", 256'(oEkY0), 256'(y_q.pop_front()));
    end
    if (oData_valid) begin
      if (d_q.size() == 0) unexp("oData_valid");
      else chk("oData", 256'(oData), 256'(d_q.pop_front()));
    end
    if (oDone) begin
      if (done_q.size() == 0) unexp("oDone");
      else begin
        g = done_q.pop_front();
        chk("done_after_data", 256'(d_q.size()), 256'(0));
        if (g >= 0) chk("done_gap", 256'(cyc - last_y), 256'(g));
      end
    end
  end

  task automatic start(input logic [0:255] k, input logic [0:95] iv, input logic [15:0] n, input bit kl, input bit ed, input bit exp);
    iKey = k; iIV = iv; iNumBlocks = n; iKeylen = kl; iEncdec = ed; iStart = 1;
    e_key = k; e_iv = iv; e_kl = kl; e_ed = ed;
    if (exp) begin
      h_q.push_back(HC ^ k[0:127]);
      y_q.push_back(YC ^ {iv, 32'h0});
      done_q.push_back(n == 0 ? 1 : -1);
    end
    @(negedge iClk);
    iStart = 0;
  endtask

  task automatic send_blk(input logic [0:127] b, input int idx);
    int t = 0;
    while (!oBlock_ready && t < 100) begin @(negedge iClk); t++; end
    chk("blk_ready", 256'(oBlock_ready), 256'(1));
    iBlock = b; iBlock_valid = 1;
    d_q.push_back(KS ^ b ^ 128'(idx));
    @(negedge iClk);
    iBlock_valid = 0;
    chk("ready_drop", 256'(oBlock_ready), 256'(0));
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (oBusy && t < 2000) begin @(negedge iClk); t++; end
    chk({nm, "_idle"}, 256'(oBusy), 256'(0));
    chk({nm, "_pending"}, 256'(h_q.size() + y_q.size() + d_q.size() + done_q.size()), 256'(0));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flags"}, 256'({oBusy, oDone, oError, oGctrRst, oGctrInit, oBlock_ready, oH_valid, oEkY0_valid,
        oData_valid, oGctrHashKey, oGctrY0, oGctrKey_valid, oGctrIV_valid, oGctrBlock_valid, oGctrKeylen, oGctrEncdec}), 256'(0));
    chk({nm, "_key"}, oGctrKey, 256'(0));
    chk({nm, "_iv_blk"}, 256'({oGctrIV, oGctrBlock}), 256'(0));
    chk({nm, "_res"}, 256'({oH, oEkY0}), 256'(0));
    chk({nm, "_data"}, 256'(oData), 256'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lows, t;
    repeat (3) @(negedge iClk);
    chk_zero("rst");
    iRst = 0;
    @(negedge iClk);
    start('0, '0, 16'd0, 0, 0, 1);
    wait_idle("n0");
    start('0, '0, 16'd1, 0, 0, 1);
    send_blk('0, 0);
    wait_idle("n1");
    start(K2, IV2, 16'd4, 1, 1, 1);
    send_blk(128'h11111111222222223333333344444444, 0);
    send_blk(128'hFFFFFFFF00000000FFFFFFFF00000000, 1);
    t = 0;
    while (!oBlock_ready && t < 100) begin @(negedge iClk); t++; end
    lows = 0;
    repeat (10) begin @(negedge iClk); if (!oBlock_ready) lows++; end
    chk("ready_hold", 256'(lows), 256'(0));
    send_blk(128'h0123456789ABCDEF0123456789ABCDEF, 2);
    send_blk(128'h80000000000000000000000000000001, 3);
    wait_idle("n4");
    start(K2, IV2, 16'd2, 0, 1, 1);
    y_q.delete();
    done_q.delete();
    t = 0;
    while (!oGctrY0 && t < 100) begin @(negedge iClk); t++; end
    chk("abort_in_y0", 256'(oGctrY0), 256'(1));
    iAbort = 1;
    @(negedge iClk);
    iAbort = 0;
    chk("abort_clr", 256'({oGctrRst, oGctrInit, oBusy}), 256'(3'b101));
    @(negedge iClk);
    chk("abort_idle", 256'({oGctrRst, oBusy}), 256'(0));
    repeat (5) @(negedge iClk);
    wait_idle("abort");
    start('0, '0, 16'd1, 0, 0, 1);
    send_blk(128'h00000000000000000000000000000001, 0);
    wait_idle("post_abort");
    start(K2, IV2, 16'd3, 1, 0, 1);
    iKey = K3; iNumBlocks = 16'd5; iStart = 1;
    @(negedge iClk);
    iStart = 0;
    chk("repeat_key", oGctrKey, K2);
    send_blk(128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 0);
    iRst = 1;
    @(negedge iClk);
    chk_zero("mid_rst");
    iRst = 0;
    h_q.delete(); y_q.delete(); d_q.delete(); done_q.delete();
    @(negedge iClk);
    start(K3, IV2, 16'd0, 1, 1, 1);
    wait_idle("post_rst");
`ifdef GCM_SEQ_TIMEOUT_EN
    hold = 1;
    start('0, '0, 16'd0, 0, 0, 0);
    wait_idle("timeout");
    chk("timeout_err", 256'(oError), 256'(1));
    hold = 0;
    start('0, '0, 16'd0, 0, 0, 1);
    chk("err_clear", 256'(oError), 256'(0));
    wait_idle("after_timeout");
`endif
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
